osram_responder: RTL and testbench

On-chip SRAM responder that sits on the 16-bit OS bus on the far side from the OSCU dirty-bitmap initiator. It stores DEPTH words of DATA_BITS and answers single-cycle OSRead/OSWrite strobes. Each read returns registered data one cycle later, and that data is held stable until the next accepted read. After reset it zero-fills the whole array with an internal init walker before it accepts traffic, so every block's dirty bitmap starts clean.

---
 rtl/osram_pkg.sv | 21 ++
 rtl/osram_array.sv | 51 +++++
 rtl/osram_responder.sv | 118 +++++++++++
 tb/tb_osram_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osram_pkg
//  Description : Shared constants and types for the OS-bus SRAM responder.
//                The address and data widths are shared with the OSCU
//                initiator, so both sides agree on the OSAdd/OSData* format.
//  Revision    : 1.0 - initial release
// ============================================================================
package osram_pkg;

  // OSAdd format: {block_address[9:0], word[1:0]}
  localparam int OSRAM_ADDR_BITS = 12;
  localparam int OSRAM_DATA_BITS = 16;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } osram_state_t;

endpackage : osram_pkg
`default_nettype wire

// File: rtl/osram_array.sv
`default_nettype none
// ============================================================================
//  Module      : osram_array
//  Description : Single-port synchronous word array. A write and a read can
//                be requested on the same port. The read data register only
//                updates on a read request and otherwise holds its value.
//                It has no reset, which matches a compiled SRAM macro so this
//                block can later be replaced by one.
//  Ports       : clk2  - clock
//                we    - write enable, writes wdata to mem[addr]
//                re    - read enable, loads rdata_q with mem[addr]
//                addr  - word address
//                wdata - write data
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module osram_array #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 4096
) (
  input  logic                 clk2,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;
  logic [DATA_BITS-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk2) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule : osram_array
`default_nettype wire

// File: rtl/osram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : osram_responder
//  Description : On-chip SRAM responder on the 16-bit OS bus. After reset an
//                init walker zero-fills the array, one word per cycle. After
//                that, single-cycle OSRead/OSWrite strobes are served with a
//                one-cycle read latency. Read data holds until the next
//                accepted read. Protocol violations raise a one-cycle ProtErr
//                pulse: any strobe during init, or read and write together.
//  Ports       : clk2      - clock
//                NReset    - asynchronous active-low reset
//                OSRead    - read strobe
//                OSWrite   - write strobe
//                OSAdd     - word address
//                OSDataout - write data from the initiator
//                OSDatain  - registered read data to the initiator
//                SramReady - high once the zero fill is complete
//                ProtErr   - one-cycle protocol violation pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module osram_responder
  import osram_pkg::*;
#(
  parameter int ADDR_BITS = OSRAM_ADDR_BITS,
  parameter int DATA_BITS = OSRAM_DATA_BITS,
  parameter int DEPTH     = 2 ** OSRAM_ADDR_BITS
) (
  input  logic                 clk2,
  input  logic                 NReset,
  input  logic                 OSRead,
  input  logic                 OSWrite,
  input  logic [ADDR_BITS-1:0] OSAdd,
  input  logic [DATA_BITS-1:0] OSDataout,
  output logic [DATA_BITS-1:0] OSDatain,
  output logic                 SramReady,
  output logic                 ProtErr
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  osram_state_t          state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic                  has_rd_q, has_rd_d;
  logic                  prot_err_q, prot_err_d;

  logic                  arr_we;
  logic                  arr_re;
  logic [ADDR_BITS-1:0]  arr_addr;
  logic [DATA_BITS-1:0]  arr_wdata;
  logic [DATA_BITS-1:0]  arr_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    has_rd_d   = has_rd_q;
    prot_err_d = 1'b0;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_addr   = OSAdd;
    arr_wdata  = OSDataout;

    if (state_q == INIT) begin
      // The init walker owns the port; bus strobes are refused and flagged.
      arr_we     = 1'b1;
      arr_addr   = cnt_q;
      arr_wdata  = '0;
      cnt_d      = cnt_q + ADDR_BITS'(1);
      prot_err_d = OSRead | OSWrite;
      if (cnt_q == LAST_ADDR) begin
        state_d = READY;
      end
    end else begin
      // Read+write collision: the write wins and the read is dropped.
      arr_we     = OSWrite;
      arr_re     = OSRead & ~OSWrite;
      prot_err_d = OSRead & OSWrite;
      if (arr_re) begin
        has_rd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      has_rd_q   <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      has_rd_q   <= has_rd_d;
      prot_err_q <= prot_err_d;
    end
  end

  osram_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk2  (clk2),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // The array's read register has no reset. Until the first accepted read
  // after reset, force zero so OSDatain has a defined reset value. Both mux
  // inputs are flops, so no input reaches an output combinationally.
  assign OSDatain  = has_rd_q ? arr_rdata : '0;
  assign SramReady = (state_q == READY);
  assign ProtErr   = prot_err_q;

endmodule : osram_responder
`default_nettype wire

// File: tb/tb_osram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osram_responder
//  Description : Self-checking bench for osram_responder. Expected read data
//                is queued when a read strobe is driven, then popped and
//                compared on the hold cycle that follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osram_responder;

  localparam int DEPTH = 4096;

  logic        clk2 = 1'b0;
  logic        NReset = 1'b0;
  logic        OSRead = 1'b0;
  logic        OSWrite = 1'b0;
  logic [11:0] OSAdd = '0;
  logic [15:0] OSDataout = '0;
  logic [15:0] OSDatain;
  logic        SramReady;
  logic        ProtErr;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  always #5 clk2 = ~clk2;

  osram_responder dut (
    .clk2      (clk2),
    .NReset    (NReset),
    .OSRead    (OSRead),
    .OSWrite   (OSWrite),
    .OSAdd     (OSAdd),
    .OSDataout (OSDataout),
    .OSDatain  (OSDatain),
    .SramReady (SramReady),
    .ProtErr   (ProtErr)
  );

  // One bus cycle: present strobes, cross the edge, sample point is 1ns
  // after the edge, then drop the strobes while address and data are held.
  task automatic drive(input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [15:0] data);
    OSRead    = rd;
    OSWrite   = wr;
    OSAdd     = addr;
    OSDataout = data;
    @(posedge clk2);
    #1;
    OSRead  = 1'b0;
    OSWrite = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!SramReady && cycles < 5000) begin
      @(posedge clk2);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    NReset = 1'b0;
    #2;
    checks++;
    if (OSDatain !== 16'h0000) begin
      errors++; $display("FAIL reset_datain: got %h expected 0000", OSDatain);
    end
    checks++;
    if (SramReady !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", SramReady);
    end
    checks++;
    if (ProtErr !== 1'b0) begin
      errors++; $display("FAIL reset_proterr: got %b expected 0", ProtErr);
    end
    @(negedge clk2);
    NReset = 1'b1;
    wait_ready(cyc);
    checks++;
    if (cyc < DEPTH || cyc > DEPTH + 1) begin
      errors++; $display("FAIL init_duration: got %0d cycles expected %0d..%0d", cyc, DEPTH, DEPTH + 1);
    end
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 3; i++) begin
      logic [11:0] a;
      a = (i == 0) ? 12'h000 : (i == 1) ? 12'h7FF : 12'hFFF;
      exp_q.push_back(16'h0000);
      drive(1'b1, 1'b0, a, 16'h0);
      exp = exp_q.pop_front();
      checks++;
      if (OSDatain !== exp) begin
        errors++; $display("FAIL idle_read_%03h: got %h expected %h", a, OSDatain, exp);
      end
    end
  endtask

  task automatic test_write_read;
    drive(1'b0, 1'b1, 12'h123, 16'hA5A5);
    exp_q.push_back(16'hA5A5);
    drive(1'b1, 1'b0, 12'h123, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL wr_rd_123: got %h expected %h", OSDatain, exp);
    end
    repeat (5) drive(1'b0, 1'b0, 12'h123, 16'h0);
    checks++;
    if (OSDatain !== 16'hA5A5) begin
      errors++; $display("FAIL hold_123: got %h expected a5a5", OSDatain);
    end
  endtask

  task automatic test_block_access;
    logic [15:0] words [4];
    words[0] = 16'h0001; words[1] = 16'h0000; words[2] = 16'h8000; words[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 12'h014 + 12'(i), words[i]);
      drive(1'b0, 1'b0, 12'h014 + 12'(i), words[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(words[i]);
      drive(1'b1, 1'b0, 12'h014 + 12'(i), 16'h0);
      exp = exp_q.pop_front();
      checks++;
      if (OSDatain !== exp) begin
        errors++; $display("FAIL block5_word%0d: got %h expected %h", i, OSDatain, exp);
      end
      drive(1'b0, 1'b0, 12'h014 + 12'(i), 16'h0);
    end
  endtask

  task automatic test_back_to_back;
    // Reads every cycle, highest address first, so each result differs.
    logic [15:0] words [4];
    words[0] = 16'h0001; words[1] = 16'h0000; words[2] = 16'h8000; words[3] = 16'hFFFF;
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(words[i]);
      drive(1'b1, 1'b0, 12'h014 + 12'(i), 16'h0);
      exp = exp_q.pop_front();
      checks++;
      if (OSDatain !== exp) begin
        errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, OSDatain, exp);
      end
    end
  endtask

  task automatic test_collision;
    drive(1'b0, 1'b1, 12'h060, 16'hBEEF);
    exp_q.push_back(16'hBEEF);
    drive(1'b1, 1'b0, 12'h060, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL coll_setup: got %h expected %h", OSDatain, exp);
    end
    drive(1'b1, 1'b1, 12'h050, 16'h1234);
    checks++;
    if (OSDatain !== 16'hBEEF) begin
      errors++; $display("FAIL coll_hold: got %h expected beef", OSDatain);
    end
    checks++;
    if (ProtErr !== 1'b1) begin
      errors++; $display("FAIL coll_proterr: got %b expected 1", ProtErr);
    end
    drive(1'b0, 1'b0, 12'h050, 16'h0);
    checks++;
    if (ProtErr !== 1'b0) begin
      errors++; $display("FAIL coll_proterr_len: got %b expected 0", ProtErr);
    end
    exp_q.push_back(16'h1234);
    drive(1'b1, 1'b0, 12'h050, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL coll_write_kept: got %h expected %h", OSDatain, exp);
    end
    checks++;
    if (ProtErr !== 1'b0) begin
      errors++; $display("FAIL clean_read_proterr: got %b expected 0", ProtErr);
    end
  endtask

  task automatic test_mid_reset_and_init_strobe;
    int cyc;
    drive(1'b0, 1'b1, 12'h020, 16'h5555);
    exp_q.push_back(16'h5555);
    drive(1'b1, 1'b0, 12'h020, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL pre_reset_020: got %h expected %h", OSDatain, exp);
    end
    #2;
    NReset = 1'b0;
    #1;
    checks++;
    if (SramReady !== 1'b0) begin
      errors++; $display("FAIL midreset_ready: got %b expected 0", SramReady);
    end
    checks++;
    if (OSDatain !== 16'h0000) begin
      errors++; $display("FAIL midreset_datain: got %h expected 0000", OSDatain);
    end
    @(negedge clk2);
    NReset = 1'b1;
    @(posedge clk2);
    #1;
    drive(1'b0, 1'b1, 12'h010, 16'hFFFF);
    checks++;
    if (ProtErr !== 1'b1) begin
      errors++; $display("FAIL init_proterr: got %b expected 1", ProtErr);
    end
    checks++;
    if (OSDatain !== 16'h0000 || SramReady !== 1'b0) begin
      errors++; $display("FAIL init_state: got datain=%h ready=%b expected 0000/0", OSDatain, SramReady);
    end
    drive(1'b0, 1'b0, 12'h010, 16'h0);
    checks++;
    if (ProtErr !== 1'b0) begin
      errors++; $display("FAIL init_proterr_len: got %b expected 0", ProtErr);
    end
    wait_ready(cyc);
    checks++;
    if (SramReady !== 1'b1) begin
      errors++; $display("FAIL refill_timeout: got %0d cycles expected ready", cyc);
    end
    exp_q.push_back(16'h0000);
    drive(1'b1, 1'b0, 12'h010, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL init_write_ignored: got %h expected %h", OSDatain, exp);
    end
    exp_q.push_back(16'h0000);
    drive(1'b1, 1'b0, 12'h020, 16'h0);
    exp = exp_q.pop_front();
    checks++;
    if (OSDatain !== exp) begin
      errors++; $display("FAIL refill_020: got %h expected %h", OSDatain, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_block_access();
    test_back_to_back();
    test_collision();
    test_mid_reset_and_init_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_osram_responder
`default_nettype wire
